// File: rtl/mem_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_request_arbiter_pkg
//  Purpose  : Shared FSM state encoding and AMO field width for the
//             data-memory request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_request_arbiter_pkg;

    // Width of the AMO funct5 field carried with every request
    localparam int AMO_TYPE_W = 5;

    // Arbiter sequencing: pick a winner, strobe it downstream, wait for the
    // atomic unit, then return the response to the winner.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_request_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_picker
//  Purpose  : Combinational round-robin winner selection. Rotates the pending
//             vector so the pointer position becomes bit 0, finds the first
//             set bit, then maps the offset back to an absolute core index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int CORE_NUMS      = 4,
    parameter int CORE_NUMS_BITS = 2
) (
    input  logic [CORE_NUMS-1:0]      pending_i,
    input  logic [CORE_NUMS_BITS-1:0] ptr_i,
    output logic                      valid_o,
    output logic [CORE_NUMS_BITS-1:0] winner_o
);

    localparam logic [CORE_NUMS_BITS:0] C_NUM_EXT = (CORE_NUMS_BITS+1)'(CORE_NUMS);

    logic [2*CORE_NUMS-1:0]  doubled;
    logic [CORE_NUMS-1:0]    rotated;
    logic [CORE_NUMS_BITS-1:0] offset;
    logic [CORE_NUMS_BITS:0] sum;

    // Doubling the vector turns the rotation into a plain part-select
    assign doubled = {pending_i, pending_i};
    assign rotated = doubled[ptr_i +: CORE_NUMS];
    assign valid_o = |pending_i;

    // Find-first-set in the rotated domain; the lowest offset wins
    always_comb begin
        offset = '0;
        for (int i = CORE_NUMS-1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = CORE_NUMS_BITS'(i);
            end
        end
    end

    // Un-rotate: (ptr + offset) mod CORE_NUMS without a divider
    always_comb begin
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= C_NUM_EXT) begin
            sum = sum - C_NUM_EXT;
        end
    end

    assign winner_o = sum[CORE_NUMS_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_request_arbiter
//  Purpose  : Buffers one request per core and serialises them round-robin
//             onto the single request port of the atomic unit. Request fields
//             stay stable from issue until the response cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_request_arbiter
    import mem_request_arbiter_pkg::*;
#(
    parameter int CORE_NUMS      = 4,
    parameter int CORE_NUMS_BITS = 2,
    parameter int XLEN           = 32
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    // core side
    input  logic [CORE_NUMS-1:0]            P_strobe_i,
    input  logic [CORE_NUMS*XLEN-1:0]       P_addr_i,
    input  logic [CORE_NUMS-1:0]            P_rw_i,
    input  logic [CORE_NUMS*XLEN-1:0]       P_data_i,
    input  logic [CORE_NUMS-1:0]            P_is_amo_i,
    input  logic [CORE_NUMS*AMO_TYPE_W-1:0] P_amo_type_i,
    output logic [CORE_NUMS-1:0]            P_done_o,
    output logic [XLEN-1:0]                 P_data_o,
    // atomic unit side
    output logic [CORE_NUMS_BITS-1:0]       core_id_o,
    output logic                            core_strobe_o,
    output logic [XLEN-1:0]                 core_addr_o,
    output logic                            core_rw_o,
    output logic [XLEN-1:0]                 core_data_o,
    output logic                            core_is_amo_o,
    output logic [AMO_TYPE_W-1:0]           core_amo_type_o,
    input  logic                            core_done_i,
    input  logic [XLEN-1:0]                 core_data_i
);

    localparam logic [CORE_NUMS_BITS-1:0] C_LAST_ID = CORE_NUMS_BITS'(CORE_NUMS-1);

    arb_state_e                state_q, state_d;
    logic [CORE_NUMS_BITS-1:0] grant_q, grant_d;
    logic [CORE_NUMS_BITS-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0]           rdata_q, rdata_d;
    logic [CORE_NUMS-1:0]      pending_q;

    logic [XLEN-1:0]           addr_q     [CORE_NUMS];
    logic [XLEN-1:0]           wdata_q    [CORE_NUMS];
    logic [AMO_TYPE_W-1:0]     amo_type_q [CORE_NUMS];
    logic [CORE_NUMS-1:0]      rw_q;
    logic [CORE_NUMS-1:0]      is_amo_q;

    logic [CORE_NUMS-1:0]      accept;
    logic [CORE_NUMS-1:0]      clear_mask;
    logic                      clear_grant;
    logic                      pick_valid;
    logic [CORE_NUMS_BITS-1:0] pick_winner;

    // A strobe from a core that already has a request buffered is dropped
    assign accept     = P_strobe_i & ~pending_q;
    assign clear_mask = clear_grant ? (CORE_NUMS'(1) << grant_q) : '0;

    rr_priority_picker #(
        .CORE_NUMS      (CORE_NUMS),
        .CORE_NUMS_BITS (CORE_NUMS_BITS)
    ) u_picker (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .valid_o   (pick_valid),
        .winner_o  (pick_winner)
    );

    // Per-core request buffers and pending flags
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q <= '0;
            rw_q      <= '0;
            is_amo_q  <= '0;
            for (int k = 0; k < CORE_NUMS; k++) begin
                addr_q[k]     <= '0;
                wdata_q[k]    <= '0;
                amo_type_q[k] <= '0;
            end
        end else begin
            // accept and clear never hit the same core: the granted core is
            // still pending in the cycle its request completes
            pending_q <= (pending_q & ~clear_mask) | accept;
            for (int k = 0; k < CORE_NUMS; k++) begin
                if (accept[k]) begin
                    addr_q[k]     <= P_addr_i[k*XLEN +: XLEN];
                    wdata_q[k]    <= P_data_i[k*XLEN +: XLEN];
                    amo_type_q[k] <= P_amo_type_i[k*AMO_TYPE_W +: AMO_TYPE_W];
                    rw_q[k]       <= P_rw_i[k];
                    is_amo_q[k]   <= P_is_amo_i[k];
                end
            end
        end
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: arbitrate, issue, wait for completion, respond
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        rdata_d     = rdata_q;
        clear_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    rdata_d     = core_data_i;
                    clear_grant = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (grant_q == C_LAST_ID) ? '0 : grant_q + CORE_NUMS_BITS'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Downstream request comes straight from the granted buffer; the buffer
    // cannot be overwritten before the response cycle has ended.
    assign core_id_o       = grant_q;
    assign core_strobe_o   = (state_q == ST_ISSUE);
    assign core_addr_o     = addr_q[grant_q];
    assign core_rw_o       = rw_q[grant_q];
    assign core_data_o     = wdata_q[grant_q];
    assign core_is_amo_o   = is_amo_q[grant_q];
    assign core_amo_type_o = amo_type_q[grant_q];

    assign P_done_o = (state_q == ST_RESP) ? (CORE_NUMS'(1) << grant_q) : '0;
    assign P_data_o = (state_q == ST_RESP) ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_request_arbiter
//  Purpose  : Self-checking bench for mem_request_arbiter: table of single
//             transactions, directed multi-cycle sequences, and random
//             traffic against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_request_arbiter;

    localparam int N = 4;
    localparam int B = 2;
    localparam int X = 32;

    logic             clk = 1'b0;
    logic             rstn_i = 1'b1;
    logic [N-1:0]     P_strobe_i = '0;
    logic [N*X-1:0]   P_addr_i = '0;
    logic [N-1:0]     P_rw_i = '0;
    logic [N*X-1:0]   P_data_i = '0;
    logic [N-1:0]     P_is_amo_i = '0;
    logic [N*5-1:0]   P_amo_type_i = '0;
    logic [N-1:0]     P_done_o;
    logic [X-1:0]     P_data_o;
    logic [B-1:0]     core_id_o;
    logic             core_strobe_o;
    logic [X-1:0]     core_addr_o;
    logic             core_rw_o;
    logic [X-1:0]     core_data_o;
    logic             core_is_amo_o;
    logic [4:0]       core_amo_type_o;
    logic             core_done_i = 1'b0;
    logic [X-1:0]     core_data_i = '0;

    always #5 clk = ~clk;

    mem_request_arbiter #(.CORE_NUMS(N), .CORE_NUMS_BITS(B), .XLEN(X)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .P_strobe_i(P_strobe_i), .P_addr_i(P_addr_i), .P_rw_i(P_rw_i),
        .P_data_i(P_data_i), .P_is_amo_i(P_is_amo_i), .P_amo_type_i(P_amo_type_i),
        .P_done_o(P_done_o), .P_data_o(P_data_o),
        .core_id_o(core_id_o), .core_strobe_o(core_strobe_o), .core_addr_o(core_addr_o),
        .core_rw_o(core_rw_o), .core_data_o(core_data_o), .core_is_amo_o(core_is_amo_o),
        .core_amo_type_o(core_amo_type_o), .core_done_i(core_done_i), .core_data_i(core_data_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // atomic-unit responder
    bit   rsp_busy = 0;
    int   rsp_cnt  = 0;
    int   rsp_dly  = 2;
    logic [X-1:0] rsp_addr = '0;
    int   last_cdone = -100;

    // observation logs
    int           iss_id[$];
    logic [X-1:0] iss_addr[$];
    logic [N-1:0] dn_vec[$];
    logic [X-1:0] dn_data[$];
    int           dn_lag[$];
    int           strobe_cnt = 0;
    bit           auto0 = 0;

    // reference model state (random phase)
    bit           model_on = 0;
    bit           mpend[N];
    int           macc[N];
    logic [X-1:0] maddr[N];
    logic [X-1:0] mdata[N];
    bit           mrw[N];
    bit           mamo[N];
    logic [4:0]   mtype[N];
    int           mptr = 0;
    int           mgrant = 0;
    bit           mbusy = 0;
    int           mfree = 0;
    int           exp_done_cyc = -10;

    typedef struct {
        int         core;
        logic [31:0] addr;
        logic       rw;
        logic [31:0] data;
        logic       amo;
        logic [4:0] typ;
        int         dly;
        logic [1:0] exp_id;
        logic [3:0] exp_done;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[4];

    // The atomic-unit stand-in answers with a fixed scramble of the address
    function automatic logic [X-1:0] resp_fn(logic [X-1:0] a);
        return a ^ 32'hDEAD_AEEF;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(int k, logic [X-1:0] a, logic rw, logic [X-1:0] d, logic amo, logic [4:0] t);
        P_strobe_i[k]          = 1'b1;
        P_addr_i[k*X +: X]     = a;
        P_rw_i[k]              = rw;
        P_data_i[k*X +: X]     = d;
        P_is_amo_i[k]          = amo;
        P_amo_type_i[k*5 +: 5] = t;
    endtask

    task automatic clear_logs();
        iss_id.delete(); iss_addr.delete();
        dn_vec.delete(); dn_data.delete(); dn_lag.delete();
        strobe_cnt = 0;
    endtask

    // One clock cycle: update the model with the inputs of the cycle that
    // just ended, check outputs, then run the responder and logs.
    task automatic tick();
        logic [N-1:0]   s_stb, s_rw, s_amo;
        logic [N*X-1:0] s_addr, s_data;
        logic [N*5-1:0] s_typ;
        logic           s_done;
        logic [N-1:0]   exp_vec;
        bit             exp_stb;
        int             win, kk;
        s_stb = P_strobe_i; s_rw = P_rw_i; s_amo = P_is_amo_i;
        s_addr = P_addr_i; s_data = P_data_i; s_typ = P_amo_type_i; s_done = core_done_i;
        @(posedge clk); #1;
        cyc++;
        if (model_on) begin
            for (int k = 0; k < N; k++) begin
                if (s_stb[k] && !mpend[k]) begin
                    mpend[k] = 1; macc[k] = cyc - 1;
                    maddr[k] = s_addr[k*X +: X]; mdata[k] = s_data[k*X +: X];
                    mrw[k] = s_rw[k]; mamo[k] = s_amo[k]; mtype[k] = s_typ[k*5 +: 5];
                end
            end
            if (s_done) begin
                mpend[mgrant] = 0;
                exp_done_cyc  = cyc;
            end
            exp_vec = (cyc == exp_done_cyc) ? (4'b0001 << mgrant) : 4'b0000;
            chk("rnd_done_vec", P_done_o, exp_vec);
            if (cyc == exp_done_cyc) begin
                chk("rnd_rdata", P_data_o, resp_fn(maddr[mgrant]));
                mptr  = (mgrant + 1) % N;
                mbusy = 0;
                mfree = cyc + 1;
            end
            exp_stb = 0; win = 0;
            if (!mbusy && (cyc - 1) >= mfree) begin
                for (int i = N-1; i >= 0; i--) begin
                    kk = (mptr + i) % N;
                    if (mpend[kk] && macc[kk] <= cyc - 2) begin
                        exp_stb = 1; win = kk;
                    end
                end
            end
            chk("rnd_strobe", core_strobe_o, exp_stb);
            if (exp_stb) begin
                chk("rnd_id", core_id_o, win);
                chk("rnd_addr", core_addr_o, maddr[win]);
                chk("rnd_wdata", core_data_o, mdata[win]);
                chk("rnd_flags", {core_rw_o, core_is_amo_o, core_amo_type_o},
                    {mrw[win], mamo[win], mtype[win]});
                mgrant = win;
                mbusy  = 1;
            end
        end
        P_strobe_i  = '0;
        core_done_i = 1'b0;
        if (rsp_busy) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                core_done_i = 1'b1;
                core_data_i = resp_fn(rsp_addr);
                rsp_busy    = 0;
                last_cdone  = cyc;
            end
        end
        if (core_strobe_o) begin
            strobe_cnt++;
            iss_id.push_back(int'(core_id_o));
            iss_addr.push_back(core_addr_o);
            rsp_busy = 1;
            rsp_addr = core_addr_o;
            rsp_cnt  = model_on ? int'($urandom_range(1, 6)) : rsp_dly;
        end
        if (P_done_o != '0) begin
            dn_vec.push_back(P_done_o);
            dn_data.push_back(P_data_o);
            dn_lag.push_back(cyc - last_cdone);
            if (auto0 && P_done_o[0]) P_strobe_i[0] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; P_strobe_i = '0; core_done_i = 1'b0;
        rsp_busy = 0; model_on = 0; auto0 = 0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        clear_logs();
    endtask

    task automatic wait_dones(int n, int bound, string name);
        int t = 0;
        while (dn_vec.size() < n && t < bound) begin
            tick();
            t++;
        end
        chk(name, dn_vec.size(), n);
    endtask

    initial begin
        int unstable;
        int n0;
        bit seen;

        tbl[0] = '{2, 32'h0000_1000, 1'b0, 32'h0000_0000, 1'b0, 5'h00, 3, 2'd2, 4'b0100, 32'hDEAD_BEEF};
        tbl[1] = '{0, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 1'b0, 5'h00, 1, 2'd0, 4'b0001, 32'hDEAD_AEEF};
        tbl[2] = '{3, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1, 5'h02, 2, 2'd3, 4'b1000, 32'h2152_5110};
        tbl[3] = '{1, 32'h1234_5678, 1'b1, 32'hA5A5_5A5A, 1'b1, 5'h1C, 5, 2'd1, 4'b0010, 32'hCC99_F897};

        // ---- reset state ----
        #1 rstn_i = 1'b0;
        #2;
        chk("rst_ctrl", {core_strobe_o, core_id_o, P_done_o, core_rw_o, core_is_amo_o, core_amo_type_o}, 64'd0);
        chk("rst_pdata", P_data_o, 64'd0);
        chk("rst_addr_data", {core_addr_o, core_data_o}, 64'd0);
        do_reset();

        // ---- table: single transactions ----
        for (int r = 0; r < 4; r++) begin
            rsp_dly = tbl[r].dly;
            clear_logs();
            drive(tbl[r].core, tbl[r].addr, tbl[r].rw, tbl[r].data, tbl[r].amo, tbl[r].typ);
            tick();
            chk("tbl_no_early_strobe", core_strobe_o, 1'b0);
            tick();
            chk("tbl_strobe_cycle2", core_strobe_o, 1'b1);
            chk("tbl_id", core_id_o, tbl[r].exp_id);
            chk("tbl_addr", core_addr_o, tbl[r].addr);
            chk("tbl_wdata", core_data_o, tbl[r].data);
            chk("tbl_flags", {core_rw_o, core_is_amo_o, core_amo_type_o}, {tbl[r].rw, tbl[r].amo, tbl[r].typ});
            wait_dones(1, 30, "tbl_done_timeout");
            chk("tbl_done_vec", dn_vec[0], tbl[r].exp_done);
            chk("tbl_rdata", dn_data[0], tbl[r].exp_rdata);
            chk("tbl_done_lag", dn_lag[0], 1);
            tick();
        end

        // ---- simultaneous strobes: grants 0,1,2,3 ----
        do_reset();
        rsp_dly = 2;
        for (int k = 0; k < N; k++) drive(k, 32'h100 * (k + 1), 1'b0, 32'h0, 1'b0, 5'h0);
        wait_dones(4, 100, "sim_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("sim_grant_order", iss_id[i], i);
            chk("sim_done_onehot", dn_vec[i], 4'b0001 << i);
        end

        // ---- fairness: core 0 re-strobes on every done, core 3 pending ----
        do_reset();
        rsp_dly = 2;
        auto0 = 1;
        drive(0, 32'h10, 1'b0, 32'h0, 1'b0, 5'h0);
        drive(3, 32'h30, 1'b0, 32'h0, 1'b0, 5'h0);
        wait_dones(3, 100, "fair_timeout");
        chk("fair_first", iss_id[0], 0);
        chk("fair_core3_before_core0", iss_id[1], 3);
        chk("fair_third", iss_id[2], 0);
        auto0 = 0;

        // ---- AMO hold for a long downstream latency ----
        do_reset();
        rsp_dly = 10;
        drive(1, 32'h0000_2000, 1'b0, 32'h0000_0005, 1'b1, 5'b00000);
        unstable = 0; seen = 0;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (core_strobe_o) seen = 1;
            if (seen && (core_addr_o !== 32'h2000 || core_is_amo_o !== 1'b1 ||
                         core_amo_type_o !== 5'b00000 || core_data_o !== 32'h5 || core_id_o !== 2'd1))
                unstable++;
            if (P_done_o != '0) break;
        end
        repeat (4) tick();
        chk("amo_fields_stable", unstable, 0);
        chk("amo_strobe_once", strobe_cnt, 1);
        chk("amo_done_seen", dn_vec.size(), 1);

        // ---- protocol errors: duplicate strobe, spurious done ----
        do_reset();
        rsp_dly = 2;
        drive(1, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 5'h0);
        tick();
        drive(1, 32'h0000_4000, 1'b0, 32'h0, 1'b0, 5'h0);
        wait_dones(1, 30, "dup_timeout");
        repeat (8) tick();
        chk("dup_orig_addr", iss_addr[0], 32'h0000_3000);
        chk("dup_dropped", iss_id.size(), 1);
        chk("dup_rdata", dn_data[0], 32'hDEAD_9EEF);
        n0 = dn_vec.size();
        core_done_i = 1'b1;
        core_data_i = 32'h1234_0000;
        repeat (5) tick();
        chk("spurious_done_ignored", dn_vec.size(), n0);
        chk("spurious_no_strobe", strobe_cnt, 1);

        // ---- asynchronous reset in WAIT ----
        do_reset();
        rsp_dly = 20;
        drive(2, 32'h0000_2222, 1'b0, 32'h0, 1'b0, 5'h0);
        drive(3, 32'h0000_3333, 1'b0, 32'h0, 1'b0, 5'h0);
        repeat (5) tick();
        chk("mid_granted_core2", core_id_o, 2);
        #1 rstn_i = 1'b0;
        #1;
        chk("mid_rst_ctrl", {core_strobe_o, core_id_o, P_done_o, core_rw_o, core_is_amo_o, core_amo_type_o}, 64'd0);
        chk("mid_rst_addr_data", {core_addr_o, core_data_o}, 64'd0);
        chk("mid_rst_pdata", P_data_o, 64'd0);
        rsp_busy = 0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        clear_logs();
        repeat (40) tick();
        chk("mid_no_done_after", dn_vec.size(), 0);
        chk("mid_no_strobe_after", strobe_cnt, 0);
        rsp_dly = 1;
        drive(1, 32'h0000_0111, 1'b0, 32'h0, 1'b0, 5'h0);
        wait_dones(1, 20, "mid_new_timeout");
        chk("mid_new_done", dn_vec[0], 4'b0010);

        // ---- random traffic against the reference model ----
        do_reset();
        for (int k = 0; k < N; k++) begin
            mpend[k] = 0; macc[k] = 0; maddr[k] = '0; mdata[k] = '0;
            mrw[k] = 0; mamo[k] = 0; mtype[k] = '0;
        end
        mptr = 0; mgrant = 0; mbusy = 0; mfree = cyc; exp_done_cyc = -10;
        model_on = 1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0)
                    drive(k, $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end
        end
        model_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
